// File: rtl/stereo_pixel_packer_if.sv
// Pixel-in / packed-pair-out bundle between the two capture paths, the packer
// and the SAD accumulator.
interface stereo_pixel_packer_if #(
  parameter int N_BYTES = 8
) ();
  logic [7:0]           left_pix;
  logic                 left_valid;
  logic                 left_sof;
  logic [7:0]           right_pix;
  logic                 right_valid;
  logic                 right_sof;
  logic [N_BYTES*8-1:0] left_camera;
  logic [N_BYTES*8-1:0] right_camera;
  logic                 in_ready;
  logic                 frame_done;
  logic                 overflow;
  logic                 sof_err;

  modport master (
    output left_pix, left_valid, left_sof, right_pix, right_valid, right_sof,
    input  left_camera, right_camera, in_ready, frame_done, overflow, sof_err
  );

  modport slave (
    input  left_pix, left_valid, left_sof, right_pix, right_valid, right_sof,
    output left_camera, right_camera, in_ready, frame_done, overflow, sof_err
  );
endinterface

// File: rtl/stereo_pixel_packer.sv
// Packs two byte streams into N_BYTES words, buffers each side in a small FIFO
// and issues aligned left/right pairs with a one-cycle strobe and frame marker.
module stereo_pixel_packer #(
  parameter int N_BYTES         = 8,
  parameter int FIFO_DEPTH      = 4,
  parameter int BEATS_PER_FRAME = 38400
) (
  input logic                  clk,
  input logic                  reset,
  stereo_pixel_packer_if.slave bus
);
  localparam int WORD_W = N_BYTES * 8;
  localparam int LW     = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int BW     = (BEATS_PER_FRAME > 1) ? $clog2(BEATS_PER_FRAME) : 1;

  logic [7:0]        pix_p0    [2];
  logic              vld_p0    [2];
  logic              sof_p0    [2];
  logic [LW-1:0]     lane      [2];
  logic [LW-1:0]     eff_lane  [2];
  logic [WORD_W-1:0] shreg     [2];
  logic [WORD_W-1:0] word_p0   [2];
  logic              push_p0   [2];
  logic              push_ok   [2];
  logic              full      [2];
  logic [WORD_W-1:0] mem       [2][FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr    [2];
  logic [AW-1:0]     rd_ptr    [2];
  logic [AW:0]       count     [2];
  logic              pop_p0;
  logic [BW-1:0]     beat;

  logic [WORD_W-1:0] left_camera_p1;
  logic [WORD_W-1:0] right_camera_p1;
  logic              vld_p1;
  logic              frame_done_p1;
  logic              overflow_r;
  logic              sof_err_r;

  assign pix_p0[0] = bus.left_pix;
  assign vld_p0[0] = bus.left_valid;
  assign sof_p0[0] = bus.left_sof;
  assign pix_p0[1] = bus.right_pix;
  assign vld_p0[1] = bus.right_valid;
  assign sof_p0[1] = bus.right_sof;

  // A pair may issue only when both sides hold a complete word.
  assign pop_p0 = (count[0] != '0) && (count[1] != '0);

  // ---- stage p0: lane select, word assembly, FIFO push decision ----
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      eff_lane[s] = sof_p0[s] ? '0 : lane[s];
      word_p0[s]  = shreg[s];
      word_p0[s][{eff_lane[s], 3'b000} +: 8] = pix_p0[s];
      push_p0[s]  = vld_p0[s] && (eff_lane[s] == LW'(N_BYTES - 1));
      full[s]     = (count[s] == (AW + 1)'(FIFO_DEPTH));
      // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
      push_ok[s]  = push_p0[s] && (!full[s] || pop_p0);
    end
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (vld_p0[s])
        shreg[s] <= word_p0[s];
      if (push_ok[s])
        mem[s][wr_ptr[s]] <= word_p0[s];
    end
  end

  // ---- stage p1: registered pair outputs, beat counter, sticky flags ----
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int s = 0; s < 2; s++) begin
        lane[s]   <= '0;
        wr_ptr[s] <= '0;
        rd_ptr[s] <= '0;
        count[s]  <= '0;
      end
      beat            <= '0;
      vld_p1          <= 1'b0;
      frame_done_p1   <= 1'b0;
      left_camera_p1  <= '0;
      right_camera_p1 <= '0;
      overflow_r      <= 1'b0;
      sof_err_r       <= 1'b0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (vld_p0[s])
          lane[s] <= push_p0[s] ? '0 : eff_lane[s] + LW'(1);
        if (vld_p0[s] && sof_p0[s] && (lane[s] != '0))
          sof_err_r <= 1'b1;
        if (push_p0[s] && !push_ok[s])
          overflow_r <= 1'b1;
        if (push_ok[s])
          wr_ptr[s] <= wr_ptr[s] + AW'(1);
        if (pop_p0)
          rd_ptr[s] <= rd_ptr[s] + AW'(1);
        case ({push_ok[s], pop_p0})
          2'b10:   count[s] <= count[s] + (AW + 1)'(1);
          2'b01:   count[s] <= count[s] - (AW + 1)'(1);
          default: count[s] <= count[s];
        endcase
      end

      vld_p1          <= pop_p0;
      left_camera_p1  <= pop_p0 ? mem[0][rd_ptr[0]] : '0;
      right_camera_p1 <= pop_p0 ? mem[1][rd_ptr[1]] : '0;
      frame_done_p1   <= pop_p0 && (beat == BW'(BEATS_PER_FRAME - 1));
      if (pop_p0)
        beat <= (beat == BW'(BEATS_PER_FRAME - 1)) ? '0 : beat + BW'(1);
    end
  end

  assign bus.left_camera  = left_camera_p1;
  assign bus.right_camera = right_camera_p1;
  assign bus.in_ready     = vld_p1;
  assign bus.frame_done   = frame_done_p1;
  assign bus.overflow     = overflow_r;
  assign bus.sof_err      = sof_err_r;
endmodule

// File: doc/stereo_pixel_packer.md
Name: stereo_pixel_packer

Overview:
- Transmit side of the stereo SAD datapath.
- Accepts two independent byte-per-clock pixel streams, one from each OV7670 capture path.
- Packs each stream into N_BYTES-wide words and buffers them in a small per-side FIFO.
- Issues aligned left/right word pairs with a one-cycle valid strobe to the SAD accumulator's left_camera/right_camera/in_ready inputs. It also marks frame boundaries.

Parameters:
- N_BYTES, 8: pixels per output word per camera.
- FIFO_DEPTH, 4: packed words buffered per side (power of 2, ≥2).
- BEATS_PER_FRAME, 38400: output pairs per frame. Must equal the downstream accumulator's frame beat count.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- left_pix  in  8  left camera pixel byte
- left_valid  in  1  left_pix valid this cycle
- left_sof  in  1  qualifies left_valid: first pixel of a frame
- right_pix  in  8  right camera pixel byte
- right_valid  in  1  right_pix valid this cycle
- right_sof  in  1  qualifies right_valid: first pixel of a frame
- left_camera  out  N_BYTES*8  packed left word
- right_camera  out  N_BYTES*8  packed right word
- in_ready  out  1  one-cycle strobe: left_camera/right_camera valid
- frame_done  out  1  one-cycle strobe coincident with last pair of a frame
- overflow  out  1  sticky: a packed word was dropped
- sof_err  out  1  sticky: sof arrived mid-word, partial word discarded

Behaviour:
- Reset (reset==0 at posedge):
  - All outputs are 0.
  - Lane counters, FIFOs, beat counter and sticky flags are cleared.
  - A reset mid-frame discards all partial and buffered data.
- No backpressure exists on the output. Stalls are absorbed only by the FIFOs.
- Packing (per side, identical logic):
  - Pixel k of a word (k=0..N_BYTES-1, in arrival order) lands in bits [8k+7:8k].
  - The lane counter advances on each valid byte.
  - On lane N_BYTES-1 the complete word (including this byte) is pushed to the side FIFO at the same clock edge, and the lane counter wraps to 0.
- SOF handling (per side):
  - valid&&sof forces this byte into lane 0.
  - If the lane counter was nonzero, the partial word is discarded and sof_err is set (sticky until reset).
  - FIFO contents are not flushed.
- FIFO (per side):
  - Push and pop in the same cycle are both permitted; occupancy is unchanged.
  - A push while full with no pop drops the incoming word, sets overflow (sticky) and leaves the FIFO unchanged.
  - A push while full with a simultaneous pop succeeds.
- Pairing/issue:
  - In any cycle where both FIFOs are non-empty, both heads are popped.
  - On the next edge the heads are registered onto left_camera/right_camera with in_ready=1 for exactly one cycle.
  - When no pair issues, in_ready=0 and the data outputs are 0 (held at 0, not stale).
- Latency: last byte of a word sampled at edge t → FIFO non-empty after t → in_ready high in the cycle after edge t+1, provided the other side is already non-empty. Minimum 2 cycles from last byte to strobe.
- Throughput: one pair per cycle sustained while both FIFOs are non-empty.
- Beat counter:
  - 16+ bits (sized by clog2(BEATS_PER_FRAME)).
  - Increments on each issued pair.
  - On the pair that makes the count equal BEATS_PER_FRAME: frame_done=1 in the same cycle as that in_ready, and the counter wraps to 0.
  - SOF does not reset the beat counter. Frame alignment is by count only.
- Skew: one side may lead the other by up to FIFO_DEPTH words without loss.

Test Plan:
- Reset/idle: hold reset=0 five cycles, then release with no valids → all outputs 0, in_ready never asserts.
- Aligned streams: left bytes 0x01..0x08 and right bytes 0x11..0x18 on the same cycles, sof on the first byte → one strobe two cycles after the 8th byte; left_camera=0x0807060504030201, right_camera=0x1817161514131211.
- Skew: left sends 3 words (bytes 0x00..0x17); right starts 30 cycles later with 3 words → no strobes until the first right word completes; then 3 pairs issue in FIFO order; overflow=0.
- Overflow: left sends 6 words, right silent, FIFO_DEPTH=4 → overflow=1 after the 5th word. Right then sends 4 words → exactly 4 strobes, carrying left words 1–4.
- SOF mid-word: left sends 3 bytes, then sof with 8 fresh bytes 0xA0..0xA7 → sof_err=1; issued left word is 0xA7A6A5A4A3A2A1A0.
- Frame wrap: BEATS_PER_FRAME=4, 9 aligned pairs → frame_done on pairs 4 and 8 only, each coincident with in_ready; reset asserted mid-frame then released → next frame_done after a further 4 pairs.
